rv32i_mem_top: RTL and testbench
================================

# rv32i_mem_top

Memory-access stage of the RV32I pipeline, between the execute stage and the writeback stage. It drives the data-memory port of the synchronous dual-port RAM:
- word address
- byte enables
- replicated store data
- write strobe

It also registers the execute-stage payload for writeback and formats the RAM read data returned one cycle later into the load result consumed by writeback. It detects misaligned accesses, suppresses their side effects, and exports mem-stage forwarding and load-pending signals to the hazard logic.

## Interface
- ADDR_W, 14, data-RAM word-address width (2^ADDR_W 32-bit words)
- clk  in  1  system clock, all state on rising edge
- reset  in  1  asynchronous, active-low reset
- pc_in, iw_in, alu_in  in  32 each  from execute stage: PC, instruction word, ALU result / effective address
- rs2_data_in  in  32  store source data
- wb_reg_in  in  5  destination register
- wb_en_in  in  1  writeback enable
- src_sel_in  in  2  writeback source select (2 = ALU, 0 = memory)
- memif_rdata  in  32  RAM read data, valid the cycle after the address was presented
- memif_addr  out  ADDR_W  word address = alu_in[ADDR_W+1:2]
- memif_we  out  1  write strobe
- memif_be  out  4  byte enables
- memif_wdata  out  32  store data
- pc_out, iw_out, alu_out  out  32 each  registered payload to writeback
- wb_reg_out  out  5  registered destination register
- wb_en_out  out  1  registered writeback enable
- src_sel_out  out  2  registered source select
- ld_data  out  32  formatted load result, feeds writeback memif_rdata input
- df_mem_enable  out  1  forwarding valid for the instruction at the inputs
- df_mem_reg  out  5  forwarding destination register
- df_mem_data  out  32  forwarding data
- ld_pending  out  1  load at inputs with wb_en_in (hazard unit stalls dependents)
- misalign_err  out  1  sticky misaligned-access flag

## Operation
- Decode from iw_in:
  - load = opcode 0000011; store = opcode 0100011
  - f3 = iw_in[14:12]; off = alu_in[1:0]
- Misaligned:
  - half access (f3[1:0]=01) with off[0]=1
  - word access (f3[1:0]=10) with off≠0
  - byte accesses never misaligned
- Store, combinational from inputs:
  - SB: be = 0001<<off, wdata = {4{rs2[7:0]}}
  - SH: be = off[1] ? 1100 : 0011, wdata = {2{rs2[15:0]}}
  - SW: be = 1111, wdata = rs2
  - memif_we = store & ~misaligned & reset
  - non-store: be = 0000, wdata = 0
- memif_addr is always driven from alu_in, so the RAM read issues every cycle.
- Pipeline register captures the payload every clock edge; no stall input.
  - wb_en_out <= wb_en_in & ~(load & misaligned)
  - Also captured: ld_f3 <= f3, ld_off <= off (internal)
- ld_data, combinational from memif_rdata plus registered ld_f3/ld_off:
  - LB/LBU (000/100): byte at ld_off, sign-/zero-extended
  - LH/LHU (001/101): half at ld_off[1], sign-/zero-extended
  - LW and all other f3: memif_rdata unchanged
- Forwarding:
  - df_mem_enable = wb_en_in & ~load
  - df_mem_reg = wb_reg_in
  - df_mem_data = alu_in
  - ld_pending = load & wb_en_in
- misalign_err sets on any edge where a misaligned load or store is at the inputs; cleared only by reset.

## Timing
- Reset, asynchronous, held while reset=0:
  - pc_out, alu_out, wb_reg_out, src_sel_out, ld_f3, ld_off, misalign_err = 0
  - wb_en_out = 0
  - iw_out = 0x00000013 (NOP)
  - memif_we forced 0
- Reset deasserted mid-program: first captured instruction is whatever is at the inputs on the first rising edge after release; no partial store is ever issued during reset.
- Latency:
  - memory port outputs are zero-cycle from the inputs
  - registered payload: 1 cycle
  - ld_data is valid in the cycle after the load was at the inputs, aligned with wb_*_out
- Back-to-back load/store every cycle supported. A store followed by a load to the same word returns the new data (RAM write-first on the same port across cycles).
- Misaligned access plus reset in the same cycle: reset wins, flag stays 0.

## Test plan
- Reset low with store at inputs (alu_in=0x10, SW) -> memif_we=0, iw_out=0x00000013, wb_en_out=0; release -> next edge captures payload.
- SB rs2=0x000000A5, alu_in=0x103 -> memif_addr=0x40, be=1000, wdata=0xA5A5A5A5, we=1.
- LB alu_in=0x102, next cycle memif_rdata=0x1280FF00 -> ld_data=0xFFFFFF80; same with LBU -> 0x00000080.
- LH alu_in=0x202, rdata=0x8001_1234 -> ld_data=0xFFFF8001; LW alu_in=0x200 -> ld_data=0x80011234.
- SW alu_in=0x102 -> we=0, misalign_err=1 after edge and stays 1; LW alu_in=0x101 with wb_en_in=1 -> wb_en_out=0.
- ADD with wb_en_in=1, wb_reg_in=5, alu_in=7 -> df_mem_enable=1, df_mem_reg=5, df_mem_data=7, ld_pending=0; LW to x5 -> df_mem_enable=0, ld_pending=1.

Source files
------------

// File: rtl/rv32i_mem_top.sv
// RV32I memory-access stage: drives the data-RAM port, registers the execute
// payload for writeback and formats RAM read data into the load result.
module rv32i_mem_top #(
    parameter int ADDR_W = 14
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [31:0]       pc_in,
    input  logic [31:0]       iw_in,
    input  logic [31:0]       alu_in,
    input  logic [31:0]       rs2_data_in,
    input  logic [4:0]        wb_reg_in,
    input  logic              wb_en_in,
    input  logic [1:0]        src_sel_in,
    input  logic [31:0]       memif_rdata,
    output logic [ADDR_W-1:0] memif_addr,
    output logic              memif_we,
    output logic [3:0]        memif_be,
    output logic [31:0]       memif_wdata,
    output logic [31:0]       pc_out,
    output logic [31:0]       iw_out,
    output logic [31:0]       alu_out,
    output logic [4:0]        wb_reg_out,
    output logic              wb_en_out,
    output logic [1:0]        src_sel_out,
    output logic [31:0]       ld_data,
    output logic              df_mem_enable,
    output logic [4:0]        df_mem_reg,
    output logic [31:0]       df_mem_data,
    output logic              ld_pending,
    output logic              misalign_err
);

    localparam logic [6:0]  OP_LOAD  = 7'b0000011;
    localparam logic [6:0]  OP_STORE = 7'b0100011;
    localparam logic [31:0] NOP      = 32'h0000_0013;

    logic       is_load;
    logic       is_store;
    logic       misaligned;
    logic [2:0] f3;
    logic [1:0] off;
    logic [2:0] ld_f3;
    logic [1:0] ld_off;

    assign is_load  = (iw_in[6:0] == OP_LOAD);
    assign is_store = (iw_in[6:0] == OP_STORE);
    assign f3       = iw_in[14:12];
    assign off      = alu_in[1:0];

    always_comb begin
        misaligned = 1'b0;
        case (f3[1:0])
            2'b01:   misaligned = off[0];
            2'b10:   misaligned = (off != 2'b00);
            default: misaligned = 1'b0;
        endcase
    end

    // The RAM read is issued every cycle; only the write side is qualified.
    assign memif_addr = alu_in[ADDR_W+1:2];

    always_comb begin
        memif_be    = 4'b0000;
        memif_wdata = 32'h0000_0000;
        if (is_store) begin
            case (f3[1:0])
                2'b00: begin
                    memif_be    = 4'b0001 << off;
                    memif_wdata = {4{rs2_data_in[7:0]}};
                end
                2'b01: begin
                    memif_be    = off[1] ? 4'b1100 : 4'b0011;
                    memif_wdata = {2{rs2_data_in[15:0]}};
                end
                default: begin
                    memif_be    = 4'b1111;
                    memif_wdata = rs2_data_in;
                end
            endcase
        end
    end

    assign memif_we = is_store & ~misaligned & reset;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_out       <= 32'h0000_0000;
            iw_out       <= NOP;
            alu_out      <= 32'h0000_0000;
            wb_reg_out   <= 5'd0;
            wb_en_out    <= 1'b0;
            src_sel_out  <= 2'd0;
            ld_f3        <= 3'd0;
            ld_off       <= 2'd0;
            misalign_err <= 1'b0;
        end else begin
            pc_out       <= pc_in;
            iw_out       <= iw_in;
            alu_out      <= alu_in;
            wb_reg_out   <= wb_reg_in;
            wb_en_out    <= wb_en_in & ~(is_load & misaligned);
            src_sel_out  <= src_sel_in;
            ld_f3        <= f3;
            ld_off       <= off;
            misalign_err <= misalign_err | ((is_load | is_store) & misaligned);
        end
    end

    // Read data arrives one cycle late, so it is steered by the registered f3/offset.
    always_comb begin
        logic [7:0]  sel_byte;
        logic [15:0] sel_half;
        sel_byte = memif_rdata[7:0];
        case (ld_off)
            2'd0:    sel_byte = memif_rdata[7:0];
            2'd1:    sel_byte = memif_rdata[15:8];
            2'd2:    sel_byte = memif_rdata[23:16];
            default: sel_byte = memif_rdata[31:24];
        endcase
        sel_half = ld_off[1] ? memif_rdata[31:16] : memif_rdata[15:0];
        case (ld_f3)
            3'b000:  ld_data = {{24{sel_byte[7]}}, sel_byte};
            3'b100:  ld_data = {24'h000000, sel_byte};
            3'b001:  ld_data = {{16{sel_half[15]}}, sel_half};
            3'b101:  ld_data = {16'h0000, sel_half};
            default: ld_data = memif_rdata;
        endcase
    end

    assign df_mem_enable = wb_en_in & ~is_load;
    assign df_mem_reg    = wb_reg_in;
    assign df_mem_data   = alu_in;
    assign ld_pending    = is_load & wb_en_in;

endmodule

// File: tb/tb_rv32i_mem_top.sv
// Directed testbench for rv32i_mem_top with hand-computed expected values.
module tb_rv32i_mem_top;

    localparam int ADDR_W = 14;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_ALU   = 7'b0110011;

    logic              clk;
    logic              reset;
    logic [31:0]       pc_in, iw_in, alu_in, rs2_data_in;
    logic [4:0]        wb_reg_in;
    logic              wb_en_in;
    logic [1:0]        src_sel_in;
    logic [31:0]       memif_rdata;
    logic [ADDR_W-1:0] memif_addr;
    logic              memif_we;
    logic [3:0]        memif_be;
    logic [31:0]       memif_wdata;
    logic [31:0]       pc_out, iw_out, alu_out;
    logic [4:0]        wb_reg_out;
    logic              wb_en_out;
    logic [1:0]        src_sel_out;
    logic [31:0]       ld_data;
    logic              df_mem_enable;
    logic [4:0]        df_mem_reg;
    logic [31:0]       df_mem_data;
    logic              ld_pending;
    logic              misalign_err;

    int passed = 0;
    int total  = 0;

    rv32i_mem_top #(.ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset),
        .pc_in(pc_in), .iw_in(iw_in), .alu_in(alu_in), .rs2_data_in(rs2_data_in),
        .wb_reg_in(wb_reg_in), .wb_en_in(wb_en_in), .src_sel_in(src_sel_in),
        .memif_rdata(memif_rdata), .memif_addr(memif_addr), .memif_we(memif_we),
        .memif_be(memif_be), .memif_wdata(memif_wdata),
        .pc_out(pc_out), .iw_out(iw_out), .alu_out(alu_out), .wb_reg_out(wb_reg_out),
        .wb_en_out(wb_en_out), .src_sel_out(src_sel_out), .ld_data(ld_data),
        .df_mem_enable(df_mem_enable), .df_mem_reg(df_mem_reg), .df_mem_data(df_mem_data),
        .ld_pending(ld_pending), .misalign_err(misalign_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mk_iw(input logic [2:0] f3, input logic [6:0] op);
        return {17'd0, f3, 5'd0, op};
    endfunction

    task automatic drive(input logic [31:0] pc, input logic [31:0] iw, input logic [31:0] alu,
                         input logic [31:0] rs2, input logic [4:0] rd, input logic en,
                         input logic [1:0] sel);
        pc_in = pc; iw_in = iw; alu_in = alu; rs2_data_in = rs2;
        wb_reg_in = rd; wb_en_in = en; src_sel_in = sel;
        #1;
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        memif_rdata = 32'h0;
        drive(32'h0000_0100, mk_iw(3'b010, OP_STORE), 32'h10, 32'h1111_2222, 5'd0, 1'b0, 2'd2);
        total++; if (memif_we !== 1'b0) $display("[TB] FAIL rst_we got %0h want 0", memif_we); else passed++;
        step();
        total++; if (iw_out !== 32'h0000_0013) $display("[TB] FAIL rst_iw_out got %08h want 00000013", iw_out); else passed++;
        total++; if (wb_en_out !== 1'b0) $display("[TB] FAIL rst_wb_en_out got %0h want 0", wb_en_out); else passed++;
        total++; if (pc_out !== 32'h0) $display("[TB] FAIL rst_pc_out got %08h want 0", pc_out); else passed++;
        drive(32'h0000_0104, mk_iw(3'b010, OP_STORE), 32'h102, 32'h0, 5'd0, 1'b0, 2'd2);
        step();
        total++; if (misalign_err !== 1'b0) $display("[TB] FAIL rst_misalign got %0h want 0", misalign_err); else passed++;
        drive(32'h0000_0200, mk_iw(3'b000, OP_ALU), 32'h55, 32'h0, 5'd3, 1'b1, 2'd2);
        reset = 1'b1;
        #1;
        step();
        total++; if (pc_out !== 32'h0000_0200) $display("[TB] FAIL rel_pc_out got %08h want 00000200", pc_out); else passed++;
        total++; if (iw_out !== mk_iw(3'b000, OP_ALU)) $display("[TB] FAIL rel_iw_out got %08h want %08h", iw_out, mk_iw(3'b000, OP_ALU)); else passed++;
        total++; if (wb_en_out !== 1'b1) $display("[TB] FAIL rel_wb_en_out got %0h want 1", wb_en_out); else passed++;
        total++; if (alu_out !== 32'h55) $display("[TB] FAIL rel_alu_out got %08h want 55", alu_out); else passed++;
        total++; if (wb_reg_out !== 5'd3) $display("[TB] FAIL rel_wb_reg_out got %0d want 3", wb_reg_out); else passed++;
    endtask

    task automatic test_store();
        drive(32'h0000_0300, mk_iw(3'b000, OP_STORE), 32'h103, 32'h0000_00A5, 5'd0, 1'b0, 2'd2);
        total++; if (memif_addr !== 14'h40) $display("[TB] FAIL sb_addr got %0h want 40", memif_addr); else passed++;
        total++; if (memif_be !== 4'b1000) $display("[TB] FAIL sb_be got %b want 1000", memif_be); else passed++;
        total++; if (memif_wdata !== 32'hA5A5_A5A5) $display("[TB] FAIL sb_wdata got %08h want a5a5a5a5", memif_wdata); else passed++;
        total++; if (memif_we !== 1'b1) $display("[TB] FAIL sb_we got %0h want 1", memif_we); else passed++;
        step();
        drive(32'h0000_0304, mk_iw(3'b001, OP_STORE), 32'h102, 32'h1234_ABCD, 5'd0, 1'b0, 2'd2);
        total++; if (memif_be !== 4'b1100) $display("[TB] FAIL sh_be got %b want 1100", memif_be); else passed++;
        total++; if (memif_wdata !== 32'hABCD_ABCD) $display("[TB] FAIL sh_wdata got %08h want abcdabcd", memif_wdata); else passed++;
        total++; if (memif_we !== 1'b1) $display("[TB] FAIL sh_we got %0h want 1", memif_we); else passed++;
        step();
        drive(32'h0000_0308, mk_iw(3'b000, OP_STORE), 32'h200, 32'h0000_00C3, 5'd0, 1'b0, 2'd2);
        total++; if (memif_be !== 4'b0001) $display("[TB] FAIL sb0_be got %b want 0001", memif_be); else passed++;
        step();
        total++; if (misalign_err !== 1'b0) $display("[TB] FAIL st_misalign got %0h want 0", misalign_err); else passed++;
    endtask

    task automatic test_loads();
        drive(32'h0000_0400, mk_iw(3'b000, OP_LOAD), 32'h102, 32'h0, 5'd6, 1'b1, 2'd0);
        total++; if (memif_be !== 4'b0000 || memif_we !== 1'b0) $display("[TB] FAIL lb_port got be=%b we=%0h want be=0000 we=0", memif_be, memif_we); else passed++;
        step();
        drive(32'h0000_0404, mk_iw(3'b100, OP_LOAD), 32'h102, 32'h0, 5'd7, 1'b1, 2'd0);
        memif_rdata = 32'h1280_FF00; #1;
        total++; if (ld_data !== 32'hFFFF_FF80) $display("[TB] FAIL lb_data got %08h want ffffff80", ld_data); else passed++;
        step();
        drive(32'h0000_0408, mk_iw(3'b001, OP_LOAD), 32'h202, 32'h0, 5'd8, 1'b1, 2'd0);
        memif_rdata = 32'h1280_FF00; #1;
        total++; if (ld_data !== 32'h0000_0080) $display("[TB] FAIL lbu_data got %08h want 00000080", ld_data); else passed++;
        step();
        drive(32'h0000_040C, mk_iw(3'b101, OP_LOAD), 32'h202, 32'h0, 5'd9, 1'b1, 2'd0);
        memif_rdata = 32'h8001_1234; #1;
        total++; if (ld_data !== 32'hFFFF_8001) $display("[TB] FAIL lh_data got %08h want ffff8001", ld_data); else passed++;
        step();
        drive(32'h0000_0410, mk_iw(3'b010, OP_LOAD), 32'h200, 32'h0, 5'd10, 1'b1, 2'd0);
        memif_rdata = 32'h8001_1234; #1;
        total++; if (ld_data !== 32'h0000_8001) $display("[TB] FAIL lhu_data got %08h want 00008001", ld_data); else passed++;
        step();
        memif_rdata = 32'h8001_1234; #1;
        total++; if (ld_data !== 32'h8001_1234) $display("[TB] FAIL lw_data got %08h want 80011234", ld_data); else passed++;
        total++; if (wb_en_out !== 1'b1) $display("[TB] FAIL lw_wb_en_out got %0h want 1", wb_en_out); else passed++;
        total++; if (wb_reg_out !== 5'd10) $display("[TB] FAIL lw_wb_reg_out got %0d want 10", wb_reg_out); else passed++;
    endtask

    task automatic test_misaligned();
        drive(32'h0000_0500, mk_iw(3'b010, OP_STORE), 32'h102, 32'hCAFE_F00D, 5'd0, 1'b0, 2'd2);
        total++; if (memif_we !== 1'b0) $display("[TB] FAIL sw_mis_we got %0h want 0", memif_we); else passed++;
        total++; if (misalign_err !== 1'b0) $display("[TB] FAIL mis_pre got %0h want 0", misalign_err); else passed++;
        step();
        total++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_set got %0h want 1", misalign_err); else passed++;
        drive(32'h0000_0504, mk_iw(3'b010, OP_LOAD), 32'h101, 32'h0, 5'd11, 1'b1, 2'd0);
        step();
        total++; if (wb_en_out !== 1'b0) $display("[TB] FAIL lw_mis_wb_en got %0h want 0", wb_en_out); else passed++;
        drive(32'h0000_0508, mk_iw(3'b001, OP_LOAD), 32'h203, 32'h0, 5'd12, 1'b1, 2'd0);
        step();
        total++; if (wb_en_out !== 1'b0) $display("[TB] FAIL lh_mis_wb_en got %0h want 0", wb_en_out); else passed++;
        drive(32'h0000_050C, mk_iw(3'b000, OP_LOAD), 32'h103, 32'h0, 5'd13, 1'b1, 2'd0);
        step();
        total++; if (wb_en_out !== 1'b1) $display("[TB] FAIL lb_odd_wb_en got %0h want 1", wb_en_out); else passed++;
        total++; if (misalign_err !== 1'b1) $display("[TB] FAIL mis_sticky got %0h want 1", misalign_err); else passed++;
    endtask

    task automatic test_forwarding();
        drive(32'h0000_0600, mk_iw(3'b000, OP_ALU), 32'h7, 32'h0, 5'd5, 1'b1, 2'd2);
        total++; if (df_mem_enable !== 1'b1) $display("[TB] FAIL add_df_en got %0h want 1", df_mem_enable); else passed++;
        total++; if (df_mem_reg !== 5'd5) $display("[TB] FAIL add_df_reg got %0d want 5", df_mem_reg); else passed++;
        total++; if (df_mem_data !== 32'h7) $display("[TB] FAIL add_df_data got %08h want 7", df_mem_data); else passed++;
        total++; if (ld_pending !== 1'b0) $display("[TB] FAIL add_ld_pend got %0h want 0", ld_pending); else passed++;
        step();
        drive(32'h0000_0604, mk_iw(3'b010, OP_LOAD), 32'h300, 32'h0, 5'd5, 1'b1, 2'd0);
        total++; if (df_mem_enable !== 1'b0) $display("[TB] FAIL lw_df_en got %0h want 0", df_mem_enable); else passed++;
        total++; if (ld_pending !== 1'b1) $display("[TB] FAIL lw_ld_pend got %0h want 1", ld_pending); else passed++;
        step();
    endtask

    task automatic test_back_to_back();
        drive(32'h0000_0700, mk_iw(3'b010, OP_STORE), 32'h300, 32'hDEAD_BEEF, 5'd0, 1'b0, 2'd2);
        total++; if (memif_we !== 1'b1 || memif_be !== 4'b1111) $display("[TB] FAIL b2b_sw got we=%0h be=%b want we=1 be=1111", memif_we, memif_be); else passed++;
        total++; if (memif_wdata !== 32'hDEAD_BEEF) $display("[TB] FAIL b2b_wdata got %08h want deadbeef", memif_wdata); else passed++;
        step();
        drive(32'h0000_0704, mk_iw(3'b010, OP_LOAD), 32'h300, 32'h0, 5'd14, 1'b1, 2'd0);
        total++; if (memif_we !== 1'b0 || memif_addr !== 14'hC0) $display("[TB] FAIL b2b_lw got we=%0h addr=%0h want we=0 addr=c0", memif_we, memif_addr); else passed++;
        step();
        memif_rdata = 32'hDEAD_BEEF; #1;
        total++; if (ld_data !== 32'hDEAD_BEEF) $display("[TB] FAIL b2b_ld_data got %08h want deadbeef", ld_data); else passed++;
        total++; if (src_sel_out !== 2'd0) $display("[TB] FAIL b2b_src_sel got %0d want 0", src_sel_out); else passed++;
    endtask

    initial begin
        test_reset();
        test_store();
        test_loads();
        test_misaligned();
        test_forwarding();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
